data_mem_responder: RTL and testbench

// - Responder (slave) end of the CPU data-memory interface. It services loads and stores

---
 rtl/data_mem_responder.sv | 163 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Responder end of the CPU data-memory interface. Services loads and stores from the
// pipeline's memory stage, inserting WAIT_CYCLES wait states and holding the pipeline
// with 'stall' until the one-cycle response is produced.
// Address space: word-addressed RAM (2**ADDR_W words), the io_out register at IO_ADDR,
// and a read-only free-running cycle counter at IO_ADDR+1.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   wmem/rmem  store / load request strobes, held stable while stall is high
//   addr       word address of the access
//   wdata      store data
//   stall      pipeline hold (accept cycle and every wait cycle)
//   rsp_valid  one-cycle pulse when the access completes
//   rdata      load data, qualified by rsp_valid
//   rsp_err    error flag, qualified by rsp_valid
//   io_out     memory-mapped output register
module data_mem_responder #(
    parameter int          ADDR_W      = 8,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] IO_ADDR     = 32'h100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wmem,
    input  logic        rmem,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        rsp_err,
    output logic [31:0] io_out
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [31:0] CNT_ADDR  = IO_ADDR + 32'd1;
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam int          DEPTH     = 1 << ADDR_W;

    state_t      state, next_state;
    logic [3:0]  wcnt, next_wcnt;
    logic        lat_w, lat_r;
    logic [31:0] lat_addr, lat_wdata;
    logic [31:0] cycle_cnt;
    logic [31:0] mem [0:DEPTH-1];

    logic              req, accept, commit;
    logic              acc_w, acc_r, acc_err;
    logic [31:0]       acc_addr, acc_wdata, read_val;
    logic              is_io, is_cnt, is_ram;
    logic              ram_we, io_we;
    logic [ADDR_W-1:0] ram_idx;

    assign req    = wmem | rmem;
    // Accept is gated by rst so stall drops the instant reset is asserted.
    assign accept = rst && (state == S_IDLE) && req;

    // With zero wait states the commit happens on the accept edge, before anything has
    // been latched, so the access fields come straight from the ports while IDLE.
    assign acc_w     = (state == S_IDLE) ? wmem  : lat_w;
    assign acc_r     = (state == S_IDLE) ? rmem  : lat_r;
    assign acc_addr  = (state == S_IDLE) ? addr  : lat_addr;
    assign acc_wdata = (state == S_IDLE) ? wdata : lat_wdata;

    // IO registers win over RAM if the two ranges ever overlap.
    assign is_io   = (acc_addr == IO_ADDR);
    assign is_cnt  = (acc_addr == CNT_ADDR);
    assign is_ram  = (acc_addr[31:ADDR_W] == '0) && !is_io && !is_cnt;
    assign ram_idx = acc_addr[ADDR_W-1:0];
    assign acc_err = (acc_w & acc_r) | ~(is_io | is_cnt | is_ram);

    assign commit = rst && (next_state == S_RESP);
    assign ram_we = commit & acc_w & ~acc_err & is_ram;
    assign io_we  = commit & acc_w & ~acc_err & is_io;

    assign stall     = accept || (rst && (state == S_WAIT));
    assign rsp_valid = (state == S_RESP);

    // Read mux: values as they stand just before the commit edge, so a load never sees
    // a store from the same access.
    always_comb begin
        read_val = '0;
        if (is_io)
            read_val = io_out;
        else if (is_cnt)
            read_val = cycle_cnt;
        else if (is_ram)
            read_val = mem[ram_idx];
    end

    // Next-state logic: IDLE -> WAIT (or straight to RESP with no wait states) -> RESP -> IDLE.
    always_comb begin
        next_state = state;
        next_wcnt  = wcnt;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        next_state = S_RESP;
                    end else begin
                        next_state = S_WAIT;
                        next_wcnt  = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (wcnt == 4'd0)
                    next_state = S_RESP;
                else
                    next_wcnt = wcnt - 4'd1;
            end
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // State register, request latch and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            wcnt      <= 4'd0;
            lat_w     <= 1'b0;
            lat_r     <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata     <= '0;
            rsp_err   <= 1'b0;
            io_out    <= '0;
        end else begin
            state <= next_state;
            wcnt  <= next_wcnt;
            if (accept) begin
                lat_w     <= wmem;
                lat_r     <= rmem;
                lat_addr  <= addr;
                lat_wdata <= wdata;
            end
            if (commit) begin
                rsp_err <= acc_err;
                rdata   <= (acc_err || !acc_r) ? 32'd0 : read_val;
            end
            if (io_we)
                io_out <= acc_wdata;
        end
    end

    // Free-running cycle counter; wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cycle_cnt <= '0;
        else
            cycle_cnt <= cycle_cnt + 32'd1;
    end

    // RAM array has no reset; writes only on a committed, error-free store.
    always_ff @(posedge clk) begin
        if (ram_we)
            mem[ram_idx] <= acc_wdata;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
// Directed bench for data_mem_responder. Two instances share the request inputs:
// dut2 uses the default two wait states, dut0 is built with zero wait states.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wmem = 1'b0;
    logic        rmem = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;

    logic        stall2, rsp_valid2, rsp_err2;
    logic [31:0] rdata2, io_out2;
    logic        stall0, rsp_valid0, rsp_err0;
    logic [31:0] rdata0, io_out0;

    int checks = 0;
    int failures = 0;

    data_mem_responder dut2 (
        .clk(clk), .rst(rst), .wmem(wmem), .rmem(rmem), .addr(addr), .wdata(wdata),
        .stall(stall2), .rsp_valid(rsp_valid2), .rdata(rdata2), .rsp_err(rsp_err2),
        .io_out(io_out2)
    );

    data_mem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .wmem(wmem), .rmem(rmem), .addr(addr), .wdata(wdata),
        .stall(stall0), .rsp_valid(rsp_valid0), .rdata(rdata0), .rsp_err(rsp_err0),
        .io_out(io_out0)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Issues one access starting in the current cycle (called just after a rising edge)
    // and waits for its response. lat counts cycles from accept to rsp_valid, stalls
    // counts cycles with stall high. With hold=1 the request stays up during RESP.
    task applyStimulus(input bit sel, input logic w, input logic r,
                       input logic [31:0] a, input logic [31:0] d, input bit hold,
                       output logic [31:0] rd, output logic err,
                       output int lat, output int stalls);
        logic done;
        done   = 1'b0;
        rd     = '0;
        err    = 1'b0;
        lat    = 0;
        stalls = 0;
        wmem   = w;
        rmem   = r;
        addr   = a;
        wdata  = d;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (sel ? stall0 : stall2) stalls++;
            if (sel ? rsp_valid0 : rsp_valid2) begin
                rd   = sel ? rdata0 : rdata2;
                err  = sel ? rsp_err0 : rsp_err2;
                done = 1'b1;
                if (!hold) begin
                    wmem = 1'b0;
                    rmem = 1'b0;
                end
            end else begin
                lat++;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("rsp_seen", {31'd0, done}, 32'd1);
    endtask

    logic [31:0] rd, c1, c2;
    logic        err;
    int          lat, st, nvalid;

    initial begin
        // Reset state, with a request pending to show stall is held low in reset.
        wmem = 1'b1;
        addr = 32'h5;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_stall2", {31'd0, stall2}, 32'd0);
        checkOutput("rst_stall0", {31'd0, stall0}, 32'd0);
        checkOutput("rst_valid", {31'd0, rsp_valid2}, 32'd0);
        checkOutput("rst_err", {31'd0, rsp_err2}, 32'd0);
        checkOutput("rst_rdata", rdata2, 32'd0);
        checkOutput("rst_io", io_out2, 32'd0);
        wmem = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // T1: store then load RAM word 5
        applyStimulus(0, 1, 0, 32'h5, 32'hDEADBEEF, 0, rd, err, lat, st);
        checkOutput("t1_st_lat", lat, 3);
        checkOutput("t1_st_stalls", st, 3);
        checkOutput("t1_st_err", {31'd0, err}, 32'd0);
        applyStimulus(0, 0, 1, 32'h5, 32'h0, 0, rd, err, lat, st);
        checkOutput("t1_ld_data", rd, 32'hDEADBEEF);
        checkOutput("t1_ld_lat", lat, 3);
        checkOutput("t1_ld_err", {31'd0, err}, 32'd0);

        // T2: io_out register and cycle counter
        applyStimulus(0, 1, 0, 32'h100, 32'h000000A5, 0, rd, err, lat, st);
        checkOutput("t2_io_out", io_out2, 32'hA5);
        applyStimulus(0, 0, 1, 32'h100, 32'h0, 0, rd, err, lat, st);
        checkOutput("t2_io_ld", rd, 32'hA5);
        applyStimulus(0, 1, 0, 32'h101, 32'h12345678, 0, rd, err, lat, st);
        checkOutput("t2_cnt_st_err", {31'd0, err}, 32'd0);
        applyStimulus(0, 0, 1, 32'h101, 32'h0, 0, c1, err, lat, st);
        applyStimulus(0, 0, 1, 32'h101, 32'h0, 0, c2, err, lat, st);
        checkOutput("t2_cnt_step", c2 - c1, 32'd4);
        checkOutput("t2_cnt_err", {31'd0, err}, 32'd0);

        // T3: unmapped addresses
        applyStimulus(0, 0, 1, 32'h2000, 32'h0, 0, rd, err, lat, st);
        checkOutput("t3_ld_err", {31'd0, err}, 32'd1);
        checkOutput("t3_ld_data", rd, 32'd0);
        applyStimulus(0, 1, 0, 32'h2005, 32'hBAD0BAD0, 0, rd, err, lat, st);
        checkOutput("t3_st_err", {31'd0, err}, 32'd1);
        applyStimulus(0, 0, 1, 32'h5, 32'h0, 0, rd, err, lat, st);
        checkOutput("t3_ram5", rd, 32'hDEADBEEF);
        applyStimulus(0, 0, 1, 32'h100, 32'h0, 0, rd, err, lat, st);
        checkOutput("t3_io", rd, 32'hA5);

        // T4: wmem and rmem together; request held through RESP is re-accepted in IDLE
        applyStimulus(0, 1, 1, 32'h5, 32'h11111111, 1, rd, err, lat, st);
        checkOutput("t4_err", {31'd0, err}, 32'd1);
        checkOutput("t4_data", rd, 32'd0);
        applyStimulus(0, 1, 1, 32'h5, 32'h11111111, 0, rd, err, lat, st);
        checkOutput("t4_held_lat", lat, 3);
        checkOutput("t4_held_err", {31'd0, err}, 32'd1);
        applyStimulus(0, 0, 1, 32'h5, 32'h0, 0, rd, err, lat, st);
        checkOutput("t4_ram5", rd, 32'hDEADBEEF);

        // T5: reset during the wait phase of a store
        applyStimulus(0, 1, 0, 32'h7, 32'h00000077, 0, rd, err, lat, st);
        applyStimulus(0, 0, 1, 32'h7, 32'h0, 0, rd, err, lat, st);
        checkOutput("t5_pre", rd, 32'h77);
        wmem  = 1'b1;
        addr  = 32'h7;
        wdata = 32'h1234;
        @(posedge clk);
        #1;
        checkOutput("t5_stall_wait", {31'd0, stall2}, 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("t5_stall", {31'd0, stall2}, 32'd0);
        checkOutput("t5_valid", {31'd0, rsp_valid2}, 32'd0);
        checkOutput("t5_err", {31'd0, rsp_err2}, 32'd0);
        checkOutput("t5_rdata", rdata2, 32'd0);
        checkOutput("t5_io", io_out2, 32'd0);
        wmem = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid2) nvalid++;
        end
        checkOutput("t5_no_rsp", nvalid, 0);
        @(posedge clk);
        #1;
        applyStimulus(0, 0, 1, 32'h7, 32'h0, 0, rd, err, lat, st);
        checkOutput("t5_ram7", rd, 32'h77);

        // T6: zero-wait-state instance, counter spacing and wrap
        applyStimulus(1, 0, 1, 32'h101, 32'h0, 0, c1, err, lat, st);
        checkOutput("t6_lat_a", lat, 1);
        applyStimulus(1, 0, 1, 32'h101, 32'h0, 0, c2, err, lat, st);
        checkOutput("t6_lat_b", lat, 1);
        checkOutput("t6_cnt_step", c2 - c1, 32'd2);
        force dut0.cycle_cnt = 32'hFFFFFFFF;
        @(negedge clk);
        release dut0.cycle_cnt;
        @(posedge clk);
        #1;
        applyStimulus(1, 0, 1, 32'h101, 32'h0, 0, rd, err, lat, st);
        checkOutput("t6_wrap", rd, 32'd0);
        checkOutput("t6_wrap_err", {31'd0, err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
